// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the five-stage pipeline.
// The reset input i_rst is active-low and asynchronous. Every output is a
// zero-latency combinational function of the inputs and the registered
// state (fsm, multi-cycle counter, memory-wait timeout counter), and every
// output is forced to 0 while reset is asserted.
module pipe_ctrl #(
    parameter int MC_W    = 5,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int PC_W    = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stallreq_id,
    input  logic            i_stallreq_ex,
    input  logic            i_ex_mc_start,
    input  logic [MC_W-1:0] i_ex_mc_len,
    input  logic            i_mem_req,
    input  logic            i_mem_ack,
    input  logic            i_flush_req,
    input  logic [PC_W-1:0] i_flush_pc,
    output logic [5:0]      o_stall,
    output logic            o_flush,
    output logic [PC_W-1:0] o_new_pc,
    output logic            o_ex_mc_done,
    output logic            o_bus_err
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MC_BUSY = 1'b1;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    logic [0:0]      r_fsm;
    logic [MC_W-1:0] r_mcCnt;
    logic [TO_W-1:0] r_toCnt;

    logic [0:0]      w_fsmNext;
    logic [MC_W-1:0] w_mcCntNext;
    logic [TO_W-1:0] w_toCntNext;

    logic            w_memWait;
    logic            w_busErr;
    logic            w_memStall;
    logic [5:0]      w_reqStall;

    // Memory-wait qualification and timeout detection; a flush suppresses the bus error.
    always_comb begin
        w_memWait  = i_mem_req & ~i_mem_ack;
        w_busErr   = w_memWait & (r_toCnt == TO_W'(TIMEOUT - 1)) & ~i_flush_req;
        w_memStall = w_memWait & ~w_busErr;
        if (i_stallreq_ex) begin
            w_reqStall = STALL_EX;
        end else if (i_stallreq_id) begin
            w_reqStall = STALL_ID;
        end else begin
            w_reqStall = STALL_NONE;
        end
    end

    // Prioritised output and next-state decode: reset, flush, memory wait, then EX/ID.
    always_comb begin
        o_stall      = STALL_NONE;
        o_flush      = 1'b0;
        o_new_pc     = '0;
        o_ex_mc_done = 1'b0;
        o_bus_err    = 1'b0;
        w_fsmNext    = r_fsm;
        w_mcCntNext  = r_mcCnt;
        w_toCntNext  = r_toCnt;

        if (!i_rst) begin
            w_fsmNext   = IDLE;
            w_mcCntNext = '0;
            w_toCntNext = '0;
        end else if (i_flush_req) begin
            o_flush     = 1'b1;
            o_new_pc    = i_flush_pc;
            w_fsmNext   = IDLE;
            w_mcCntNext = '0;
            w_toCntNext = '0;
        end else begin
            o_bus_err   = w_busErr;
            w_toCntNext = w_memStall ? (r_toCnt + TO_W'(1)) : '0;

            if (w_memStall) begin
                o_stall = STALL_MEM;
            end else if (r_fsm == IDLE) begin
                if (i_ex_mc_start) begin
                    if (i_ex_mc_len <= MC_W'(1)) begin
                        o_ex_mc_done = 1'b1;
                    end else begin
                        o_stall     = STALL_EX;
                        w_mcCntNext = i_ex_mc_len - MC_W'(1);
                        w_fsmNext   = MC_BUSY;
                    end
                end else begin
                    o_stall = w_reqStall;
                end
            end else begin
                if (r_mcCnt == MC_W'(1)) begin
                    o_ex_mc_done = 1'b1;
                    o_stall      = w_reqStall;
                    w_mcCntNext  = '0;
                    w_fsmNext    = IDLE;
                end else begin
                    o_stall     = STALL_EX;
                    w_mcCntNext = r_mcCnt - MC_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_fsm   <= IDLE;
            r_mcCnt <= '0;
            r_toCnt <= '0;
        end else begin
            r_fsm   <= w_fsmNext;
            r_mcCnt <= w_mcCntNext;
            r_toCnt <= w_toCntNext;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven directed bench for pipe_ctrl with TIMEOUT=8.
// Each table row is one clock cycle: inputs are driven after the falling
// edge and the outputs are compared shortly afterwards, before the next
// rising edge.
module tb_pipe_ctrl;

    localparam int MC_W    = 5;
    localparam int TIMEOUT = 8;
    localparam int TO_W    = 8;
    localparam int PC_W    = 32;

    logic            clk;
    logic            rst;
    logic            stallreqId;
    logic            stallreqEx;
    logic            exMcStart;
    logic [MC_W-1:0] exMcLen;
    logic            memReq;
    logic            memAck;
    logic            flushReq;
    logic [PC_W-1:0] flushPc;
    logic [5:0]      stall;
    logic            flush;
    logic [PC_W-1:0] newPc;
    logic            exMcDone;
    logic            busErr;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        rst;
        logic        id;
        logic        ex;
        logic        start;
        logic [4:0]  len;
        logic        req;
        logic        ack;
        logic        fl;
        logic [31:0] fpc;
        logic [5:0]  eStall;
        logic        eFlush;
        logic [31:0] eNewPc;
        logic        eDone;
        logic        eBerr;
    } vector_t;

    vector_t vq[$];

    pipe_ctrl #(
        .MC_W   (MC_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W),
        .PC_W   (PC_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_stallreq_id(stallreqId),
        .i_stallreq_ex(stallreqEx),
        .i_ex_mc_start(exMcStart),
        .i_ex_mc_len  (exMcLen),
        .i_mem_req    (memReq),
        .i_mem_ack    (memAck),
        .i_flush_req  (flushReq),
        .i_flush_pc   (flushPc),
        .o_stall      (stall),
        .o_flush      (flush),
        .o_new_pc     (newPc),
        .o_ex_mc_done (exMcDone),
        .o_bus_err    (busErr)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vector_t mkVec(
        input logic rst_v, input logic id, input logic ex, input logic start,
        input logic [4:0] len, input logic req, input logic ack, input logic fl,
        input logic [31:0] fpc, input logic [5:0] eStall, input logic eFlush,
        input logic [31:0] eNewPc, input logic eDone, input logic eBerr);
        vector_t v;
        v.rst = rst_v; v.id = id; v.ex = ex; v.start = start; v.len = len;
        v.req = req; v.ack = ack; v.fl = fl; v.fpc = fpc;
        v.eStall = eStall; v.eFlush = eFlush; v.eNewPc = eNewPc;
        v.eDone = eDone; v.eBerr = eBerr;
        return v;
    endfunction

    task automatic checkField(input string name, input int idx,
                              input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic checkOutput(input int idx, input logic [5:0] eStall, input logic eFlush,
                               input logic [31:0] eNewPc, input logic eDone, input logic eBerr);
        checkField("stall", idx, 32'(stall), 32'(eStall));
        checkField("flush", idx, 32'(flush), 32'(eFlush));
        checkField("new_pc", idx, newPc, eNewPc);
        checkField("ex_mc_done", idx, 32'(exMcDone), 32'(eDone));
        checkField("bus_err", idx, 32'(busErr), 32'(eBerr));
    endtask

    task automatic applyStimulus(input vector_t v);
        @(negedge clk);
        rst        = v.rst;
        stallreqId = v.id;
        stallreqEx = v.ex;
        exMcStart  = v.start;
        exMcLen    = v.len;
        memReq     = v.req;
        memAck     = v.ack;
        flushReq   = v.fl;
        flushPc    = v.fpc;
        #2;
    endtask

    // Directed table plus hand-written corner sequences.
    initial begin
        vector_t v;
        int doneAt;

        rst = 1'b0; stallreqId = 1'b0; stallreqEx = 1'b0; exMcStart = 1'b0;
        exMcLen = '0; memReq = 1'b0; memAck = 1'b0; flushReq = 1'b0; flushPc = '0;

        //                 rst id ex st len req ack fl fpc       stall      fl newpc     dn be
        vq.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 1, 1, 0, 0, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        // len=5: four EX stall cycles, done on cycle 5, idle on cycle 6
        vq.push_back(mkVec(1, 0, 0, 1, 5, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'b001111, 0, 32'h0, 0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   1, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0));
        // len=1 and len=0 complete in the same cycle
        vq.push_back(mkVec(1, 0, 0, 1, 1, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   1, 0));
        vq.push_back(mkVec(1, 0, 0, 1, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   1, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0));
        // memory timeout: seven MEM stall cycles then one bus_err pulse
        for (int i = 0; i < TIMEOUT - 1; i++)
            vq.push_back(mkVec(1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 6'b011111, 0, 32'h0, 0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 1, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 1));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 1, 0, 0, 32'h0,   6'b011111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 1, 1, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0));
        // len=4 with memory wait on cycles 2 and 3: done moves to cycle 6
        vq.push_back(mkVec(1, 0, 0, 1, 4, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 1, 0, 0, 32'h0,   6'b011111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 1, 0, 0, 32'h0,   6'b011111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   1, 0));
        // flush during MC_BUSY alongside stallreq_id aborts the op
        vq.push_back(mkVec(1, 0, 0, 1, 5, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 1, 32'h180, 6'b000000, 1, 32'h180, 0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0));
        // flush coinciding with the ex_mc_done cycle suppresses done
        vq.push_back(mkVec(1, 0, 0, 1, 2, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 1, 32'h40,  6'b000000, 1, 32'h40,  0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0));
        // asynchronous reset mid-op: outputs zero even with active requests, then a fresh start
        vq.push_back(mkVec(1, 0, 0, 1, 5, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(0, 1, 1, 0, 0, 1, 0, 1, 32'h180, 6'b000000, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 1, 3, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b001111, 0, 32'h0,   0, 0));
        vq.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   6'b000000, 0, 32'h0,   1, 0));

        foreach (vq[i]) begin
            applyStimulus(vq[i]);
            checkOutput(i, vq[i].eStall, vq[i].eFlush, vq[i].eNewPc, vq[i].eDone, vq[i].eBerr);
        end

        // Flush on the would-be bus_err cycle: flush wins and the timeout counter clears.
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            v = mkVec(1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 6'b011111, 0, 32'h0, 0, 0);
            applyStimulus(v);
            checkOutput(1000 + i, v.eStall, v.eFlush, v.eNewPc, v.eDone, v.eBerr);
        end
        v = mkVec(1, 0, 0, 0, 0, 1, 0, 1, 32'h200, 6'b000000, 1, 32'h200, 0, 0);
        applyStimulus(v);
        checkOutput(1100, v.eStall, v.eFlush, v.eNewPc, v.eDone, v.eBerr);
        v = mkVec(1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 6'b011111, 0, 32'h0, 0, 0);
        applyStimulus(v);
        checkOutput(1101, v.eStall, v.eFlush, v.eNewPc, v.eDone, v.eBerr);
        v = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0);
        applyStimulus(v);
        checkOutput(1102, v.eStall, v.eFlush, v.eNewPc, v.eDone, v.eBerr);

        // Bounded wait for completion of a len=3 op; done must land on cycle 3.
        doneAt = 0;
        for (int c = 1; c <= 20 && doneAt == 0; c++) begin
            if (c == 1) begin
                v = mkVec(1, 0, 0, 1, 3, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0);
            end else begin
                v = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0);
            end
            applyStimulus(v);
            if (exMcDone) doneAt = c;
        end
        checkField("mc3_done_cycle", 1200, 32'(doneAt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
